// File: rtl/sim_run_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM states, termination
// cause codes and small width helpers used to size internal counters.
package sim_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_END    = 2'd1;
    localparam logic [1:0] CAUSE_MAXCYC = 2'd2;
    localparam logic [1:0] CAUSE_HANG   = 2'd3;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_run_prio_enc.sv
// Lowest-index-first priority encoder over the end-request sources.
// any_o is high when any request is set; idx_o names the lowest set bit.
module sim_run_prio_enc #(
    parameter int N_SRC = 2,
    parameter int SRC_W = 1
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             any_o,
    output logic [SRC_W-1:0] idx_o
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        any_o = |req_i;
        idx_o = {SRC_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = SRC_W'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences core reset, counts RUN cycles,
// arbitrates end requests, applies max-cycle / no-commit aborts, drains and
// raises a sticky sim_done with pass/fail and exit information.
// Optional feature macro: SIM_RUN_CTRL_HANG_WDT_EN enables the no-commit
// hang watchdog; without it commit_valid is ignored and HANG never occurs.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int  N_SRC        = 2,
    parameter int  CODE_W       = 32,
    parameter int  CNT_W        = 64,
    parameter int  RST_CYCLES   = 5,
    parameter int  MAX_CYCLES   = 0,
    parameter int  HANG_CYCLES  = 1000,
    parameter int  DRAIN_CYCLES = 4,
    localparam int SRC_W        = idx_width(N_SRC)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        end_req,
    input  logic [N_SRC*CODE_W-1:0] end_code,
    input  logic                    commit_valid,
    output logic                    core_reset,
    output logic                    running,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic                    sim_done,
    output logic                    sim_pass,
    output logic [1:0]              cause,
    output logic [SRC_W-1:0]        exit_src,
    output logic [CODE_W-1:0]       exit_code
);

    localparam int HOLD_W  = cnt_width(RST_CYCLES);
    localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);
    localparam logic             MAX_EN   = (MAX_CYCLES != 32'sd0);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                core_reset_q, core_reset_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [1:0]          cause_q, cause_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [CODE_W-1:0]   code_q, code_d;

    logic                enc_any;
    logic [SRC_W-1:0]    enc_idx;
    logic [CODE_W-1:0]   win_code;
    logic                hang_hit;

    sim_run_prio_enc #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_prio (
        .req_i (end_req),
        .any_o (enc_any),
        .idx_o (enc_idx)
    );

    // Select the exit code belonging to the winning source.
    always_comb begin
        win_code = {CODE_W{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if (enc_idx == SRC_W'(i)) begin
                win_code = end_code[i*CODE_W +: CODE_W];
            end else begin
                win_code = win_code;
            end
        end
    end

`ifdef SIM_RUN_CTRL_HANG_WDT_EN
    localparam int               IDLE_W    = cnt_width(HANG_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HANG_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle counter: cleared by a commit, otherwise counts RUN cycles.
    always_comb begin
        idle_d   = idle_q;
        hang_hit = 1'b0;
        if (state_q == ST_RUN) begin
            hang_hit = !commit_valid && (idle_q == IDLE_LAST);
            idle_d   = commit_valid ? {IDLE_W{1'b0}} : (idle_q + IDLE_W'(1));
        end else begin
            idle_d = idle_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q <= {IDLE_W{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic wdt_unused;
    assign wdt_unused = commit_valid ^ (HANG_CYCLES == 32'sd0);
    assign hang_hit   = 1'b0;
`endif

    // Next-state and capture logic for the HOLD/RUN/DRAIN/DONE sequence.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        drain_d      = drain_q;
        cnt_d        = cnt_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        pass_d       = pass_q;
        cause_d      = cause_q;
        src_d        = src_q;
        code_d       = code_q;
        case (state_q)
            ST_HOLD: begin
                core_reset_d = 1'b1;
                if (hold_q <= HOLD_W'(1)) begin
                    hold_d       = {HOLD_W{1'b0}};
                    core_reset_d = 1'b0;
                    state_d      = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));
                if (enc_any) begin
                    cause_d = CAUSE_END;
                    src_d   = enc_idx;
                    code_d  = win_code;
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                    state_d = ST_DRAIN;
                end else if (MAX_EN && (cnt_q == MAX_LAST)) begin
                    cause_d = CAUSE_MAXCYC;
                    code_d  = {CODE_W{1'b0}};
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                    state_d = ST_DRAIN;
                end else if (hang_hit) begin
                    cause_d = CAUSE_HANG;
                    code_d  = {CODE_W{1'b0}};
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == {DRAIN_W{1'b0}}) begin
                    done_d  = 1'b1;
                    pass_d  = (cause_q == CAUSE_END) && (code_q == {CODE_W{1'b0}});
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d      = ST_HOLD;
                core_reset_d = 1'b1;
            end
        endcase
    end

    // State, counter and capture registers; reset restores the pre-run state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_q       <= HOLD_W'(RST_CYCLES);
            drain_q      <= {DRAIN_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            cause_q      <= CAUSE_NONE;
            src_q        <= {SRC_W{1'b0}};
            code_q       <= {CODE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            drain_q      <= drain_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            cause_q      <= cause_d;
            src_q        <= src_d;
            code_q       <= code_d;
        end
    end

    assign core_reset = core_reset_q;
    assign running    = (state_q == ST_RUN);
    assign cycle_cnt  = cnt_q;
    assign sim_done   = done_q;
    assign sim_pass   = pass_q;
    assign cause      = cause_q;
    assign exit_src   = src_q;
    assign exit_code  = code_q;

endmodule
